// File: rtl/fpga_robots_game_ps2_rx_pkg.sv
// Shared definitions for the PS/2 receiver.
// Error codes reported on err_code, FSM state encoding, and the
// odd-parity helper used at the stop bit.
package fpga_robots_game_ps2_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [1:0] PS2_ERR_NONE    = 2'd0;
  localparam logic [1:0] PS2_ERR_FRAME   = 2'd1;
  localparam logic [1:0] PS2_ERR_PARITY  = 2'd2;
  localparam logic [1:0] PS2_ERR_TIMEOUT = 2'd3;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/fpga_robots_game_ps2_rx_if.sv
// Byte delivery channel from the PS/2 receiver to game-play logic.
//   rx_data  : received scan-code byte
//   rx_valid : rx_data holds an unconsumed byte
//   rx_ready : consumer takes the byte this cycle
//   err      : one-cycle frame error pulse
//   err_code : error kind while err=1 (1 framing, 2 parity, 3 timeout)
interface fpga_robots_game_ps2_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       err;
  logic [1:0] err_code;

  modport master (output rx_data, rx_valid, err, err_code, input rx_ready);
  modport slave  (input rx_data, rx_valid, err, err_code, output rx_ready);
endinterface

// File: rtl/fpga_robots_game_ps2_filter.sv
// PS/2 clock conditioning: two-flop synchronizer, glitch filter and fall detect.
//   clk, rst : system clock, asynchronous active-high reset
//   raw      : raw PS/2 clock pin
//   level    : filtered clock level (idles high)
//   fall     : one-cycle pulse when level goes 1 -> 0
// level only changes after FILTER_LEN consecutive synced samples that
// differ from it; any agreeing sample restarts the count.
module fpga_robots_game_ps2_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall
);

  logic       sync1;
  logic       sync2;
  logic [3:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours (sync1 -> sync2 chain).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      fall  <= 1'b0;
      if (sync2 != level) begin
        if (cnt == 4'(FILTER_LEN - 1)) begin
          level <= sync2;
          cnt   <= '0;
          fall  <= level;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/fpga_robots_game_ps2_rx.sv
// Receive-only PS/2 keyboard port.
//   clk, rst     : system clock, asynchronous active-high reset
//   sixus        : one-cycle tick every 6 us, timebase for timeout and hold-off
//   ps2_clk_in   : raw PS/2 clock pin
//   ps2_dat_in   : raw PS/2 data pin
//   ps2_clk_low  : 1 = pull the PS/2 clock pin low to inhibit the keyboard
//   rx           : byte delivery channel (valid/ready) plus error pulse
// Frames are 11 bits (start, 8 data LSB-first, odd parity, stop), decoded
// on filtered clock falls. The keyboard is held off while a byte is pending
// and for HOLD_TICKS afterwards, so a byte is never overwritten.
module fpga_robots_game_ps2_rx
  import fpga_robots_game_ps2_rx_pkg::*;
#(
  parameter int FILTER_LEN    = 4,
  parameter int TIMEOUT_TICKS = 334,
  parameter int HOLD_TICKS    = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic sixus,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic ps2_clk_low,
  fpga_robots_game_ps2_rx_if.master rx
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  logic          clk_level;
  logic          clk_fall;
  logic          dat_s1;
  logic          dat_s2;
  logic          fall_acc;
  ps2_state_t    state;
  ps2_state_t    state_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    sr;
  logic          par;
  logic [TW-1:0] to_cnt;
  logic [HW-1:0] hold_cnt;
  logic          timeout_hit;
  logic          err_set;
  logic [1:0]    err_code_set;
  logic          deliver_set;
  logic          deliver_q;

  fpga_robots_game_ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk   (clk),
    .rst   (rst),
    .raw   (ps2_clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  // Our own inhibit pulls the clock line low; that fall is not a data bit.
  assign fall_acc    = clk_fall & ~clk_level & ~ps2_clk_low;
  assign timeout_hit = (state != ST_IDLE) && sixus && (to_cnt == TW'(TIMEOUT_TICKS - 1));

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_next   = state;
    err_set      = 1'b0;
    err_code_set = PS2_ERR_NONE;
    deliver_set  = 1'b0;
    if (ps2_clk_low) begin
      state_next = ST_IDLE;
    end else if (fall_acc) begin
      // A fall wins over a coincident timeout.
      unique case (state)
        ST_IDLE: begin
          if (!dat_s2) begin
            state_next = ST_DATA;
          end else begin
            err_set      = 1'b1;
            err_code_set = PS2_ERR_FRAME;
          end
        end
        ST_DATA:   if (bit_cnt == 3'd7) state_next = ST_PARITY;
        ST_PARITY: state_next = ST_STOP;
        ST_STOP: begin
          state_next = ST_IDLE;
          if (!dat_s2) begin
            err_set      = 1'b1;
            err_code_set = PS2_ERR_FRAME;
          end else if (!parity_ok(sr, par)) begin
            err_set      = 1'b1;
            err_code_set = PS2_ERR_PARITY;
          end else begin
            deliver_set = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next   = ST_IDLE;
      err_set      = 1'b1;
      err_code_set = PS2_ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_s1      <= 1'b1;
      dat_s2      <= 1'b1;
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      sr          <= '0;
      par         <= 1'b0;
      to_cnt      <= '0;
      hold_cnt    <= '0;
      deliver_q   <= 1'b0;
      ps2_clk_low <= 1'b0;
      rx.rx_data  <= '0;
      rx.rx_valid <= 1'b0;
      rx.err      <= 1'b0;
      rx.err_code <= PS2_ERR_NONE;
    end else begin
      dat_s1      <= ps2_dat_in;
      dat_s2      <= dat_s1;
      state       <= state_next;
      deliver_q   <= deliver_set;
      rx.err      <= err_set;
      rx.err_code <= err_code_set;
      ps2_clk_low <= rx.rx_valid | (hold_cnt != '0);

      if (fall_acc) begin
        unique case (state)
          ST_IDLE:   bit_cnt <= '0;
          ST_DATA: begin
            sr      <= {dat_s2, sr[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: par <= dat_s2;
          default: ;
        endcase
      end

      if (ps2_clk_low || fall_acc || state == ST_IDLE || timeout_hit)
        to_cnt <= '0;
      else if (sixus)
        to_cnt <= to_cnt + 1'b1;

      // Delivery lands one cycle after the stop-bit fall; sr is idle by then.
      if (deliver_q) begin
        rx.rx_data  <= sr;
        rx.rx_valid <= 1'b1;
        hold_cnt    <= HW'(HOLD_TICKS);
      end else begin
        if (rx.rx_valid && rx.rx_ready)
          rx.rx_valid <= 1'b0;
        if (sixus && hold_cnt != '0)
          hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpga_robots_game_ps2_rx.sv
// Self-checking bench for fpga_robots_game_ps2_rx. The sixus tick is
// compressed to one pulse every 20 clocks so whole frames fit in a short
// run; a bit period of 260 clocks is 13 ticks (~78 us in tick units).
module tb_fpga_robots_game_ps2_rx;
  import fpga_robots_game_ps2_rx_pkg::*;

  localparam int HALF    = 130;
  localparam int SIX_DIV = 20;

  typedef struct packed {
    logic       is_err;
    logic [1:0] code;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sixus = 1'b0;
  logic ps2_clk_in = 1'b1;
  logic ps2_dat_in = 1'b1;
  logic ps2_clk_low;

  fpga_robots_game_ps2_rx_if rx_if ();

  fpga_robots_game_ps2_rx dut (
    .clk         (clk),
    .rst         (rst),
    .sixus       (sixus),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_dat_in  (ps2_dat_in),
    .ps2_clk_low (ps2_clk_low),
    .rx          (rx_if)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   tick_cnt = 0;
  int   deliver_tick = 0;
  int   err_tick = 0;
  int   fall_tick = 0;
  int   stab_viol = 0;
  logic valid_d = 1'b0;
  logic [7:0] data_d = '0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (SIX_DIV - 1) @(negedge clk);
      sixus = 1'b1;
      @(negedge clk);
      sixus = 1'b0;
    end
  end

  always @(posedge clk) if (sixus) tick_cnt <= tick_cnt + 1;

  // Output monitor: records every delivery and error pulse.
  always @(negedge clk) begin
    if (rst) begin
      valid_d = 1'b0;
    end else begin
      if (rx_if.err === 1'b1) begin
        obs_q.push_back({1'b1, rx_if.err_code, 8'h00});
        err_tick = tick_cnt;
      end
      if (rx_if.rx_valid === 1'b1 && valid_d !== 1'b1) begin
        obs_q.push_back({1'b0, 2'd0, rx_if.rx_data});
        deliver_tick = tick_cnt;
      end
      if (rx_if.rx_valid === 1'b1 && valid_d === 1'b1 && rx_if.rx_data !== data_d)
        stab_viol++;
      valid_d = rx_if.rx_valid;
      data_d  = rx_if.rx_data;
    end
  end

  function automatic ev_t ev_byte(input logic [7:0] b);
    return {1'b0, 2'd0, b};
  endfunction

  function automatic ev_t ev_err(input logic [1:0] c);
    return {1'b1, c, 8'h00};
  endfunction

  task automatic send_bit(input logic b, input int glitch);
    ps2_dat_in = b;
    if (glitch > 0) begin
      repeat (HALF / 2) @(negedge clk);
      ps2_clk_in = 1'b0;
      repeat (glitch) @(negedge clk);
      ps2_clk_in = 1'b1;
      repeat (HALF - HALF / 2 - glitch) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk_in = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good_par, input bit stop, input int glitch);
    logic p;
    p = good_par ? ~^b : ^b;
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(p, glitch);
    send_bit(stop, glitch);
    ps2_dat_in = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic pop_pair(input int budget, output ev_t got, output ev_t want, output bit ok);
    int n = 0;
    while (obs_q.size() == 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok   = (obs_q.size() != 0) && (exp_q.size() != 0);
    got  = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
  endtask

  task automatic consume();
    @(negedge clk);
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    #1;
  endtask

  task automatic wait_release(input int budget, output bit ok);
    int n = 0;
    while (ps2_clk_low !== 1'b0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = (ps2_clk_low === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({ps2_clk_low, rx_if.rx_valid, rx_if.rx_data, rx_if.err, rx_if.err_code} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got clk_low=%b valid=%b data=%h err=%b code=%0d want all 0",
               ps2_clk_low, rx_if.rx_valid, rx_if.rx_data, rx_if.err, rx_if.err_code);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic_hold();
    ev_t got, want;
    bit  ok;
    exp_q.push_back(ev_byte(8'h1C));
    send_frame(8'h1C, 1'b1, 1'b1, 0);
    pop_pair(200, got, want, ok);
    n_cmp++;
    if (!ok || got !== want) begin
      n_bad++;
      $display("FAIL basic_1c: got %h want %h (ok=%0d)", got, want, ok);
    end
    repeat (500) @(negedge clk);
    #1;
    n_cmp++;
    if ({ps2_clk_low, rx_if.rx_valid} !== 2'b11) begin
      n_bad++;
      $display("FAIL basic_inhibit_pending: got clk_low=%b valid=%b want 1 1", ps2_clk_low, rx_if.rx_valid);
    end
    consume();
    n_cmp++;
    if (rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 8'h1C) begin
      n_bad++;
      $display("FAIL basic_consume: got valid=%b data=%h want 0 1c", rx_if.rx_valid, rx_if.rx_data);
    end
    wait_release(5, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL basic_release: got clk_low=%b want 0 within 5 cycles of consume", ps2_clk_low);
    end
  endtask

  task automatic test_parity();
    ev_t got, want;
    bit  ok;
    exp_q.push_back(ev_err(PS2_ERR_PARITY));
    send_frame(8'hF0, 1'b0, 1'b1, 0);
    pop_pair(200, got, want, ok);
    n_cmp++;
    if (!ok || got !== want) begin
      n_bad++;
      $display("FAIL parity_f0: got %h want %h (ok=%0d)", got, want, ok);
    end
    n_cmp++;
    if (rx_if.rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL parity_no_valid: got valid=%b want 0", rx_if.rx_valid);
    end
    exp_q.push_back(ev_byte(8'h29));
    send_frame(8'h29, 1'b1, 1'b1, 0);
    pop_pair(200, got, want, ok);
    n_cmp++;
    if (!ok || got !== want) begin
      n_bad++;
      $display("FAIL parity_next_29: got %h want %h (ok=%0d)", got, want, ok);
    end
    consume();
    wait_release(1000, ok);
    n_cmp++;
    if (!ok || (tick_cnt - deliver_tick) != 17) begin
      n_bad++;
      $display("FAIL hold_ticks: got %0d ticks (released=%0d) want 17", tick_cnt - deliver_tick, ok);
    end
  endtask

  task automatic test_framing();
    ev_t got, want;
    bit  ok;
    exp_q.push_back(ev_err(PS2_ERR_FRAME));
    send_frame(8'h33, 1'b1, 1'b0, 0);
    pop_pair(200, got, want, ok);
    n_cmp++;
    if (!ok || got !== want) begin
      n_bad++;
      $display("FAIL framing_stop0: got %h want %h (ok=%0d)", got, want, ok);
    end
    exp_q.push_back(ev_err(PS2_ERR_FRAME));
    send_bit(1'b1, 0);
    repeat (HALF) @(negedge clk);
    pop_pair(200, got, want, ok);
    n_cmp++;
    if (!ok || got !== want) begin
      n_bad++;
      $display("FAIL framing_lone_fall: got %h want %h (ok=%0d)", got, want, ok);
    end
  endtask

  task automatic test_timeout();
    ev_t got, want;
    bit  ok;
    logic [7:0] b;
    b = 8'hA5;
    exp_q.push_back(ev_err(PS2_ERR_TIMEOUT));
    send_bit(1'b0, 0);
    send_bit(b[0], 0);
    send_bit(b[1], 0);
    // Last fall placed just after a tick so tick counting starts cleanly.
    ps2_dat_in = b[2];
    repeat (HALF) @(negedge clk);
    @(posedge clk);
    while (sixus !== 1'b1) @(posedge clk);
    @(negedge clk);
    ps2_clk_in = 1'b0;
    fall_tick = tick_cnt;
    repeat (HALF) @(negedge clk);
    ps2_clk_in = 1'b1;
    ps2_dat_in = 1'b1;
    pop_pair(400 * SIX_DIV, got, want, ok);
    n_cmp++;
    if (!ok || got !== want) begin
      n_bad++;
      $display("FAIL timeout_err: got %h want %h (ok=%0d)", got, want, ok);
    end
    n_cmp++;
    if ((err_tick - fall_tick) != 334) begin
      n_bad++;
      $display("FAIL timeout_ticks: got %0d want 334", err_tick - fall_tick);
    end
    while ((tick_cnt - fall_tick) < 335) @(negedge clk);
    exp_q.push_back(ev_byte(8'h5A));
    send_frame(8'h5A, 1'b1, 1'b1, 0);
    pop_pair(200, got, want, ok);
    n_cmp++;
    if (!ok || got !== want) begin
      n_bad++;
      $display("FAIL timeout_next_5a: got %h want %h (ok=%0d)", got, want, ok);
    end
    consume();
    wait_release(1000, ok);
  endtask

  task automatic test_glitch();
    ev_t got, want;
    bit  ok;
    exp_q.push_back(ev_byte(8'h1C));
    send_frame(8'h1C, 1'b1, 1'b1, 3);
    pop_pair(200, got, want, ok);
    n_cmp++;
    if (!ok || got !== want) begin
      n_bad++;
      $display("FAIL glitch3_1c: got %h want %h (ok=%0d)", got, want, ok);
    end
    consume();
    wait_release(1000, ok);
    // A 4-cycle low pulse in IDLE with data high is a real fall: framing error.
    exp_q.push_back(ev_err(PS2_ERR_FRAME));
    ps2_dat_in = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk_in = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk_in = 1'b1;
    pop_pair(200, got, want, ok);
    n_cmp++;
    if (!ok || got !== want) begin
      n_bad++;
      $display("FAIL glitch4_edge: got %h want %h (ok=%0d)", got, want, ok);
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    ev_t got, want;
    bit  ok;
    logic [7:0] b;
    b = 8'h76;
    send_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 0);
    ps2_dat_in = ~^b;
    repeat (HALF) @(negedge clk);
    ps2_clk_in = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ps2_clk_low, rx_if.rx_valid, rx_if.rx_data, rx_if.err, rx_if.err_code} !== 13'd0) begin
      n_bad++;
      $display("FAIL midframe_reset_outputs: got clk_low=%b valid=%b data=%h err=%b code=%0d want all 0",
               ps2_clk_low, rx_if.rx_valid, rx_if.rx_data, rx_if.err, rx_if.err_code);
    end
    repeat (10) @(negedge clk);
    ps2_clk_in = 1'b1;
    ps2_dat_in = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    repeat (HALF) @(negedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL midframe_no_err: got %0d output events want 0", obs_q.size());
      obs_q.delete();
    end
    exp_q.push_back(ev_byte(8'h76));
    send_frame(8'h76, 1'b1, 1'b1, 0);
    pop_pair(200, got, want, ok);
    n_cmp++;
    if (!ok || got !== want) begin
      n_bad++;
      $display("FAIL midframe_next_76: got %h want %h (ok=%0d)", got, want, ok);
    end
    consume();
    wait_release(1000, ok);
  endtask

  task automatic test_final();
    repeat (50) @(negedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_events: got %0d observed / %0d expected pending want 0 / 0",
               obs_q.size(), exp_q.size());
    end
    n_cmp++;
    if (stab_viol != 0) begin
      n_bad++;
      $display("FAIL data_stable: got %0d changes of rx_data while valid want 0", stab_viol);
    end
  endtask

  initial begin
    rx_if.rx_ready = 1'b0;
    #1;
    test_reset();
    test_basic_hold();
    test_parity();
    test_framing();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_final();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
